// File: rtl/div_pkg.sv
// Shared types and sizing for the multi-cycle signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor magnitude
// from the shifted partial remainder and keep the result only if non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] trial_s;

    // Two guard bits keep the borrow visible even for a 2^31 divisor magnitude.
    always_comb begin
        shifted_s = {1'b0, rem, dividend_bit};
        trial_s   = shifted_s - {2'b00, divisor_mag};
        q_bit     = ~trial_s[WIDTH+1];
        if (q_bit) begin
            rem_next = trial_s[WIDTH-1:0];
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_unit.sv
// 32-bit signed multi-cycle divider: lo = quotient, hi = remainder.
// Optional build macro DIV_ZERO_TRAP_EN short-circuits a zero divisor to DONE.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    div_state_t       state_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvsr_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic [5:0]       cnt_r;

    logic [WIDTH-1:0] dividend_mag_s;
    logic [WIDTH-1:0] divisor_mag_s;
    logic [WIDTH-1:0] rem_next_s;
    logic             q_bit_s;

    // Magnitudes are taken modulo 2^WIDTH, so the most negative value maps to itself.
    always_comb begin
        if (dividend[WIDTH-1]) begin
            dividend_mag_s = -dividend;
        end else begin
            dividend_mag_s = dividend;
        end
        if (divisor[WIDTH-1]) begin
            divisor_mag_s = -divisor;
        end else begin
            divisor_mag_s = divisor;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_r),
        .dividend_bit (quo_r[WIDTH-1]),
        .divisor_mag  (dvsr_r),
        .rem_next     (rem_next_s),
        .q_bit        (q_bit_s)
    );

`ifdef DIV_ZERO_TRAP_EN
    logic div_zero_r;
    assign div_zero = div_zero_r;
`else
    assign div_zero = 1'b0;
`endif

    // Control FSM and datapath; quo_r shifts dividend bits out while quotient bits shift in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            dvsr_r  <= '0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            cnt_r   <= 6'd0;
`ifdef DIV_ZERO_TRAP_EN
            div_zero_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        rem_r   <= '0;
                        cnt_r   <= 6'd0;
                        quo_r   <= dividend_mag_s;
                        dvsr_r  <= divisor_mag_s;
                        q_neg_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_r <= dividend[WIDTH-1];
`ifdef DIV_ZERO_TRAP_EN
                        div_zero_r <= (divisor == '0);
                        if (divisor == '0) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= CALC;
                        end
`else
                        state_r <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= {quo_r[WIDTH-2:0], q_bit_s};
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == LAST_STEP) begin
                        state_r <= SIGN;
                    end
                end
                SIGN: begin
                    lo      <= q_neg_r ? -quo_r : quo_r;
                    hi      <= r_neg_r ? -rem_r : rem_r;
                    done    <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed operands, expected results queued at issue.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    div_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h want 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            end
        end
    end

    // Issue one operation in the current cycle; returns in its done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int lat);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = cyc + lat;
        sb.push_back(e);
        last_hi = ehi;
        last_lo = elo;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 32'hA5A5_5A5A;
        divisor  = 32'h0000_0000;
        repeat (lat - 1) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        reset = 1'b1; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;

        // 100 / 7 with busy profile and a stray start in cycle 10
        @(posedge clk); #1;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7; c0 = cyc;
        sb.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0, cyc: c0 + 34});
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); #1;
            start = 1'b0; dividend = 32'hDEAD_BEEF; divisor = 32'd0;
            if (k == 10) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3;
            end
            check("busy_profile", {31'd0, busy}, (k <= 34) ? 32'd1 : 32'd0);
        end
        run_op(32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 34);

        @(posedge clk); #1; run_op(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        @(posedge clk); #1; run_op(32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34);
        @(posedge clk); #1; run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);
`ifdef DIV_ZERO_TRAP_EN
        @(posedge clk); #1; run_op(32'd5, 32'd0, last_hi, last_lo, 1'b1, 1);
        @(posedge clk); #1; run_op(32'hFFFF_FFF8, 32'd0, last_hi, last_lo, 1'b1, 1);
`else
        @(posedge clk); #1; run_op(32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 34);
        @(posedge clk); #1; run_op(32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'd1, 1'b0, 34);
`endif
        @(posedge clk); #1; run_op(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 34);

        // Reset in cycle 20 of a 100 / 7 run aborts it with no done pulse
        @(posedge clk); #1;
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 20) reset = 1'b1;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        run_op(32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 34);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
